// File: rtl/speed_ctrl_pkg.sv
// Types, constants and helpers shared by the speed controller and its tick generator.
package speed_ctrl_pkg;

`include "speed_defs.vh"

  localparam int unsigned LevelW        = `SPEED_LEVEL_W;
  localparam int unsigned DefMaxLevel   = `SPEED_MAX_LEVEL;
  localparam int unsigned DefBaseCycles = `SPEED_BASE_CYCLES;

  typedef logic [LevelW-1:0] level_t;

  // Decoded change request; ReqHold is a request swallowed by saturation.
  typedef enum logic [1:0] {
    ReqNone,
    ReqUp,
    ReqDown,
    ReqHold
  } req_e;

  function automatic int unsigned period_of(int unsigned base, level_t lvl);
    return base >> lvl;
  endfunction

endpackage

// File: rtl/speed_ctrl_if.sv
// Request/status bundle between the key FSM (master) and the speed controller (slave).
interface speed_ctrl_if;
  import speed_ctrl_pkg::*;

  logic   enable;
  logic   up_down;
  level_t speed;
  logic   tick;
  logic   at_max;
  logic   at_min;

  modport master (
    output enable,
    output up_down,
    input  speed,
    input  tick,
    input  at_max,
    input  at_min
  );

  modport slave (
    input  enable,
    input  up_down,
    output speed,
    output tick,
    output at_max,
    output at_min
  );
endinterface

// File: rtl/speed_ctrl_tick_gen.sv
// Prescaler: counts 0..iTERM, wraps, and emits a registered one-cycle tick after the terminal count.
module tick_gen #(
  parameter int unsigned CntW = 26
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  input  logic            iCLEAR,
  input  logic [CntW-1:0] iTERM,
  output logic            oTICK
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;

  // A clear outranks the terminal count so a level change never yields a stray tick.
  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    tick_d = 1'b0;
    if (iCLEAR) begin
      cnt_d = '0;
    end else if (cnt_q >= iTERM) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign oTICK = tick_q;

endmodule

// File: rtl/speed_defs.vh
// Shared constants for the speed controller: level width and default parameter values.
`ifndef SPEED_DEFS_VH
`define SPEED_DEFS_VH

`define SPEED_LEVEL_W     3
`define SPEED_MAX_LEVEL   7
`define SPEED_BASE_CYCLES 50_000_000

`endif

// File: rtl/speed_ctrl.sv
// Saturating speed-level register with a tick output whose period halves per level.
module speed_ctrl
  import speed_ctrl_pkg::*;
#(
  parameter int unsigned BASE_CYCLES = DefBaseCycles,
  parameter int unsigned MAX_LEVEL   = DefMaxLevel,
  parameter int unsigned RESET_LEVEL = 0
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  input  logic         iENABLE,
  input  logic         iUP_DOWN,
  output logic [2:0]   oSPEED,
  output logic         oTICK,
  output logic         oAT_MAX,
  output logic         oAT_MIN
);

  localparam int unsigned CntW = $clog2(BASE_CYCLES);

  if (MAX_LEVEL > (2 ** LevelW) - 1) begin : g_bad_max
    $error("MAX_LEVEL does not fit in the level register");
  end
  if (64'(BASE_CYCLES) < (64'd1 << (MAX_LEVEL + 1))) begin : g_bad_base
    $error("BASE_CYCLES must be at least 2^(MAX_LEVEL+1)");
  end
  if (RESET_LEVEL > MAX_LEVEL) begin : g_bad_reset
    $error("RESET_LEVEL must not exceed MAX_LEVEL");
  end

  level_t          level_q, level_d;
  req_e            req;
  logic            change;
  logic [CntW-1:0] term;

  always_comb begin
    req = ReqNone;
    if (iENABLE) begin
      if (iUP_DOWN) begin
        req = (level_q == level_t'(MAX_LEVEL)) ? ReqHold : ReqUp;
      end else begin
        req = (level_q == '0) ? ReqHold : ReqDown;
      end
    end
  end

  always_comb begin
    level_d = level_q;
    unique case (req)
      ReqUp:   level_d = level_q + level_t'(1);
      ReqDown: level_d = level_q - level_t'(1);
      default: level_d = level_q;
    endcase
  end

  // Saturated requests are not changes and must leave the prescaler phase alone.
  assign change = (req == ReqUp) || (req == ReqDown);
  assign term   = CntW'(period_of(BASE_CYCLES, level_q) - 32'd1);

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      level_q <= level_t'(RESET_LEVEL);
    end else begin
      level_q <= level_d;
    end
  end

  tick_gen #(
    .CntW (CntW)
  ) u_tick_gen (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .iCLEAR (change),
    .iTERM  (term),
    .oTICK  (oTICK)
  );

  assign oSPEED  = level_q;
  assign oAT_MAX = (level_q == level_t'(MAX_LEVEL));
  assign oAT_MIN = (level_q == '0);

endmodule
